sound_glu: RTL and testbench

SOUND_GLU -- requirements
Module: sound_glu

---
 rtl/sound_glu_pkg.sv | 22 ++
 rtl/sound_glu.sv | 143 ++++++++++++++
 tb/tb_sound_glu.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_glu_pkg.sv
// Shared definitions for the sound GLU: bus register offsets, control bit
// positions and the access sequencer states.
package sound_glu_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_ADDR_LO = 2'd2;
  localparam logic [1:0] REG_ADDR_HI = 2'd3;

  localparam int CTRL_BUSY     = 7;
  localparam int CTRL_TARGET   = 6;
  localparam int CTRL_AUTO_INC = 5;
  localparam int CTRL_VOL_MSB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DOC = 2'd1,
    ST_DOC_ACC  = 2'd2,
    ST_RAM_ACC  = 2'd3
  } state_t;

endpackage

// File: rtl/sound_glu.sv
// Sound GLU: bus-visible control/data/address registers that sequence
// single-byte accesses to either the DOC or the sound RAM.
//
// state       | meaning
// ST_IDLE     | no access in flight, data register accepts strobes
// ST_WAIT_DOC | DOC access pending until doc_ready_i rises
// ST_DOC_ACC  | doc_cs_n_o low, counting down DOC_ACCESS_CYCLES
// ST_RAM_ACC  | RAM strobe held until ram_ready_i
module sound_glu
  import sound_glu_pkg::*;
#(
  parameter int DOC_ACCESS_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [1:0]  a2_reg_i,
  input  logic        a2_rd_i,
  input  logic        a2_wr_i,
  input  logic [7:0]  a2_data_i,
  output logic [7:0]  a2_data_o,
  output logic        doc_cs_n_o,
  output logic        doc_we_n_o,
  output logic [7:0]  doc_addr_o,
  output logic [7:0]  doc_data_o,
  input  logic [7:0]  doc_data_i,
  input  logic        doc_ready_i,
  output logic [15:0] ram_addr_o,
  output logic [7:0]  ram_data_o,
  output logic        ram_rd_o,
  output logic        ram_wr_o,
  input  logic        ram_ready_i,
  input  logic [7:0]  ram_data_i,
  output logic [3:0]  volume_o
);

  localparam logic [3:0] DOC_CYC = 4'(DOC_ACCESS_CYCLES);

  state_t      state;
  logic [15:0] addr;
  logic [15:0] acc_addr;
  logic [7:0]  latch;
  logic        target;
  logic        auto_inc;
  logic [3:0]  volume;
  logic        acc_write;
  logic        acc_inc;
  logic [3:0]  cnt;

  logic        busy;
  logic        start;
  logic        done;
  logic [15:0] addr_next;

  assign busy  = (state != ST_IDLE);
  assign start = (state == ST_IDLE) && (a2_reg_i == REG_DATA) && (a2_wr_i || a2_rd_i);
  assign done  = ((state == ST_DOC_ACC) && (cnt == 4'd1)) ||
                 ((state == ST_RAM_ACC) && ram_ready_i);

  // Bus byte writes override the auto-increment for the byte they touch.
  always_comb begin
    addr_next = addr;
    if (done && acc_inc) addr_next = addr + 16'd1;
    if (a2_wr_i && (a2_reg_i == REG_ADDR_LO)) addr_next[7:0]  = a2_data_i;
    if (a2_wr_i && (a2_reg_i == REG_ADDR_HI)) addr_next[15:8] = a2_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      addr      <= 16'h0000;
      acc_addr  <= 16'h0000;
      latch     <= 8'h00;
      target    <= 1'b0;
      auto_inc  <= 1'b0;
      volume    <= 4'h0;
      acc_write <= 1'b0;
      acc_inc   <= 1'b0;
      cnt       <= 4'h0;
    end else begin
      addr <= addr_next;
      if (a2_wr_i && (a2_reg_i == REG_CTRL)) begin
        target   <= a2_data_i[CTRL_TARGET];
        auto_inc <= a2_data_i[CTRL_AUTO_INC];
        volume   <= a2_data_i[CTRL_VOL_MSB:0];
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_addr  <= addr;
            acc_write <= a2_wr_i;
            acc_inc   <= auto_inc;
            cnt       <= DOC_CYC;
            if (a2_wr_i) latch <= a2_data_i;
            if (target)           state <= ST_RAM_ACC;
            else if (doc_ready_i) state <= ST_DOC_ACC;
            else                  state <= ST_WAIT_DOC;
          end
        end
        ST_WAIT_DOC: begin
          if (doc_ready_i) state <= ST_DOC_ACC;
        end
        ST_DOC_ACC: begin
          if (cnt == 4'd1) begin
            if (!acc_write) latch <= doc_data_i;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RAM_ACC: begin
          if (ram_ready_i) begin
            if (!acc_write) latch <= ram_data_i;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    a2_data_o = 8'h00;
    case (a2_reg_i)
      REG_CTRL:    a2_data_o = {busy, target, auto_inc, 1'b0, volume};
      REG_DATA:    a2_data_o = latch;
      REG_ADDR_LO: a2_data_o = addr[7:0];
      REG_ADDR_HI: a2_data_o = addr[15:8];
      default:     a2_data_o = 8'h00;
    endcase
  end

  // Strobes decode straight from state so a reset releases them at once.
  assign doc_cs_n_o = (state != ST_DOC_ACC);
  assign doc_we_n_o = !((state == ST_DOC_ACC) && acc_write);
  assign doc_addr_o = acc_addr[7:0];
  assign doc_data_o = latch;
  assign ram_rd_o   = (state == ST_RAM_ACC) && !acc_write;
  assign ram_wr_o   = (state == ST_RAM_ACC) && acc_write;
  assign ram_addr_o = acc_addr;
  assign ram_data_o = latch;
  assign volume_o   = volume;

endmodule

// File: tb/tb_sound_glu.sv
// Directed bench for sound_glu: DOC/RAM accesses, one-behind reads,
// auto-increment wrap, busy handling and mid-access reset.
module tb_sound_glu;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  a2_reg;
  logic        a2_rd, a2_wr;
  logic [7:0]  a2_wdata, a2_rdata;
  logic        doc_cs_n, doc_we_n;
  logic [7:0]  doc_addr, doc_wdata, doc_rdata;
  logic        doc_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_rd, ram_wr, ram_ready;
  logic        ram_go;
  logic [3:0]  volume;

  int n_err = 0;
  int n_chk = 0;

  int          cs_cnt = 0, we_cnt = 0, ramw_cnt = 0;
  logic [7:0]  mon_doc_addr = 8'h00, mon_doc_data = 8'h00;
  logic [15:0] mon_ram_addr = 16'h0000;
  logic [7:0]  mon_ram_data = 8'h00;

  always #5 clk_sys = ~clk_sys;

  assign ram_ready = (ram_rd | ram_wr) & ram_go;
  assign ram_rdata = (ram_addr == 16'h1000) ? 8'h11 :
                     (ram_addr == 16'h1001) ? 8'h22 : 8'h00;

  sound_glu #(.DOC_ACCESS_CYCLES(2)) dut (
    .clk_i(clk_sys), .reset_n_i(reset_n),
    .a2_reg_i(a2_reg), .a2_rd_i(a2_rd), .a2_wr_i(a2_wr),
    .a2_data_i(a2_wdata), .a2_data_o(a2_rdata),
    .doc_cs_n_o(doc_cs_n), .doc_we_n_o(doc_we_n),
    .doc_addr_o(doc_addr), .doc_data_o(doc_wdata), .doc_data_i(doc_rdata),
    .doc_ready_i(doc_ready),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
    .ram_rd_o(ram_rd), .ram_wr_o(ram_wr),
    .ram_ready_i(ram_ready), .ram_data_i(ram_rdata),
    .volume_o(volume)
  );

  // Mid-low-phase monitor: one sample per cycle, after inputs have settled.
  always @(negedge clk_sys) begin
    #2;
    if (!doc_cs_n) begin
      cs_cnt++;
      if (!doc_we_n) we_cnt++;
      mon_doc_addr = doc_addr;
      mon_doc_data = doc_wdata;
    end
    if (ram_wr && ram_ready) begin
      ramw_cnt++;
      mon_ram_addr = ram_addr;
      mon_ram_data = ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk_sys);
    a2_reg = r; a2_wdata = d; a2_wr = 1'b1; a2_rd = 1'b0;
    @(negedge clk_sys);
    a2_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] r, output logic [7:0] d);
    @(negedge clk_sys);
    a2_reg = r; a2_rd = 1'b1; a2_wr = 1'b0;
    #1 d = a2_rdata;
    @(negedge clk_sys);
    a2_rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] r, output logic [7:0] d);
    a2_reg = r;
    #1 d = a2_rdata;
  endtask

  task automatic peek_addr(output logic [15:0] a);
    logic [7:0] lo, hi;
    peek(2'd2, lo);
    peek(2'd3, hi);
    a = {hi, lo};
  endtask

  task automatic set_addr(input logic [15:0] a);
    bus_wr(2'd2, a[7:0]);
    bus_wr(2'd3, a[15:8]);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      peek(2'd0, c);
      if (!c[7]) break;
    end
    check({tag, "_idle"}, {15'h0, c[7]}, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    a2_reg = 2'd0; a2_rd = 1'b0; a2_wr = 1'b0; a2_wdata = 8'h00;
    ram_go = 1'b1; doc_ready = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  logic [7:0]  rv;
  logic [15:0] av;
  int base_cs, base_we, base_rw;

  initial begin
    reset_n = 1'b0;
    a2_reg = 2'd0; a2_rd = 1'b0; a2_wr = 1'b0; a2_wdata = 8'h00;
    ram_go = 1'b1; doc_ready = 1'b1; doc_rdata = 8'hC3;
    #1;
    check("rst_ctrl_async", {8'h0, a2_rdata}, 16'h0000);
    check("rst_cs_n", {15'h0, doc_cs_n}, 16'h0001);
    check("rst_we_n", {15'h0, doc_we_n}, 16'h0001);
    check("rst_ram_strb", {14'h0, ram_rd, ram_wr}, 16'h0000);
    check("rst_volume", {12'h0, volume}, 16'h0000);
    do_reset();
    peek(2'd1, rv); check("rst_latch", {8'h0, rv}, 16'h0000);
    peek_addr(av);  check("rst_addr", av, 16'h0000);

    // Control register readback: bit7 read-only, bit4 reads 0.
    bus_wr(2'd0, 8'hFA);
    peek(2'd0, rv); check("ctrl_rb", {8'h0, rv}, 16'h006A);
    check("volume", {12'h0, volume}, 16'h000A);
    bus_wr(2'd0, 8'h1F);
    peek(2'd0, rv); check("ctrl_rb2", {8'h0, rv}, 16'h000F);

    // DOC write, two cs-low cycles.
    bus_wr(2'd0, 8'h00);
    set_addr(16'h00A0);
    base_cs = cs_cnt; base_we = we_cnt;
    bus_wr(2'd1, 8'h55);
    peek(2'd0, rv); check("doc_busy1", {15'h0, rv[7]}, 16'h0001);
    wait_idle("doc_wr");
    check("doc_cs_cycles", 16'(cs_cnt - base_cs), 16'd2);
    check("doc_we_cycles", 16'(we_cnt - base_we), 16'd2);
    check("doc_addr", {8'h0, mon_doc_addr}, 16'h00A0);
    check("doc_data", {8'h0, mon_doc_data}, 16'h0055);
    peek_addr(av); check("doc_noinc", av, 16'h00A0);

    // One-behind RAM reads with auto-increment.
    do_reset();
    bus_wr(2'd0, 8'h60);
    set_addr(16'h1000);
    bus_rd(2'd1, rv); check("ram_rd1", {8'h0, rv}, 16'h0000); wait_idle("ram_rd1");
    bus_rd(2'd1, rv); check("ram_rd2", {8'h0, rv}, 16'h0011); wait_idle("ram_rd2");
    bus_rd(2'd1, rv); check("ram_rd3", {8'h0, rv}, 16'h0022); wait_idle("ram_rd3");
    peek_addr(av); check("ram_rd_addr", av, 16'h1003);

    // Auto-increment wrap.
    set_addr(16'hFFFF);
    base_rw = ramw_cnt;
    bus_wr(2'd1, 8'h7E);
    wait_idle("wrap");
    check("wrap_cnt", 16'(ramw_cnt - base_rw), 16'd1);
    check("wrap_ram_addr", mon_ram_addr, 16'hFFFF);
    check("wrap_ram_data", {8'h0, mon_ram_data}, 16'h007E);
    peek_addr(av); check("wrap_addr", av, 16'h0000);

    // Address-high write coinciding with auto-increment completion.
    set_addr(16'h10FF);
    ram_go = 1'b0;
    base_rw = ramw_cnt;
    bus_wr(2'd1, 8'h01);
    @(negedge clk_sys);
    ram_go = 1'b1; a2_reg = 2'd3; a2_wdata = 8'h55; a2_wr = 1'b1;
    @(negedge clk_sys);
    a2_wr = 1'b0;
    peek(2'd0, rv); check("coll_idle", {15'h0, rv[7]}, 16'h0000);
    check("coll_ram_addr", mon_ram_addr, 16'h10FF);
    peek_addr(av); check("coll_addr", av, 16'h5500);

    // DOC not ready: hold in WAIT_DOC.
    bus_wr(2'd0, 8'h00);
    set_addr(16'h0042);
    doc_ready = 1'b0;
    base_cs = cs_cnt;
    bus_wr(2'd1, 8'h99);
    repeat (5) @(negedge clk_sys);
    peek(2'd0, rv); check("wait_busy", {15'h0, rv[7]}, 16'h0001);
    check("wait_no_cs", 16'(cs_cnt - base_cs), 16'd0);
    doc_ready = 1'b1;
    wait_idle("wait_doc");
    check("wait_cs_cycles", 16'(cs_cnt - base_cs), 16'd2);
    check("wait_doc_data", {8'h0, mon_doc_data}, 16'h0099);
    check("wait_doc_addr", {8'h0, mon_doc_addr}, 16'h0042);

    // DOC one-behind read.
    bus_rd(2'd1, rv); check("doc_rd1", {8'h0, rv}, 16'h0099); wait_idle("doc_rd1");
    bus_rd(2'd1, rv); check("doc_rd2", {8'h0, rv}, 16'h00C3); wait_idle("doc_rd2");

    // Read and write together: write wins.
    base_we = we_cnt;
    @(negedge clk_sys);
    a2_reg = 2'd1; a2_wdata = 8'h3C; a2_wr = 1'b1; a2_rd = 1'b1;
    @(negedge clk_sys);
    a2_wr = 1'b0; a2_rd = 1'b0;
    wait_idle("rdwr");
    check("rdwr_we_cycles", 16'(we_cnt - base_we), 16'd2);
    check("rdwr_doc_data", {8'h0, mon_doc_data}, 16'h003C);

    // Data write while RAM access is stalled is ignored.
    do_reset();
    bus_wr(2'd0, 8'h40);
    set_addr(16'h2000);
    ram_go = 1'b0;
    base_rw = ramw_cnt;
    bus_wr(2'd1, 8'hAB);
    bus_wr(2'd1, 8'hCD);
    check("stall_wr_strobe", {15'h0, ram_wr}, 16'h0001);
    peek(2'd1, rv); check("stall_latch", {8'h0, rv}, 16'h00AB);
    ram_go = 1'b1;
    wait_idle("stall");
    repeat (3) @(negedge clk_sys);
    check("stall_wr_cnt", 16'(ramw_cnt - base_rw), 16'd1);
    check("stall_ram_data", {8'h0, mon_ram_data}, 16'h00AB);
    check("stall_ram_addr", mon_ram_addr, 16'h2000);

    // Reset in the middle of a RAM write.
    bus_wr(2'd0, 8'h4F);
    ram_go = 1'b0;
    bus_wr(2'd1, 8'h77);
    check("abort_pre_wr", {15'h0, ram_wr}, 16'h0001);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("abort_wr", {15'h0, ram_wr}, 16'h0000);
    peek(2'd0, rv); check("abort_ctrl", {8'h0, rv}, 16'h0000);
    @(negedge clk_sys);
    reset_n = 1'b1; ram_go = 1'b1;
    @(negedge clk_sys);
    peek(2'd1, rv); check("abort_latch", {8'h0, rv}, 16'h0000);
    peek_addr(av);  check("abort_addr", av, 16'h0000);
    check("abort_volume", {12'h0, volume}, 16'h0000);
    check("abort_no_wr", {14'h0, ram_rd, ram_wr}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
